// File: rtl/execute_pkg.sv
// Shared definitions for the parametrised execute stage: funct3 encodings for
// the ALU, conditional branches and the M extension, plus the md FSM states.
package execute_pkg;

  // ALU operation select (funct3)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Branch condition select (funct3); 010 and 011 are never taken
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Multiply/divide operation select (funct3)
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Operand a is treated as signed by MUL, MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input logic [2:0] op);
    return op[2] ? !op[0] : (op[1:0] != 2'b11);
  endfunction

  // Operand b is treated as signed by MUL, MULH, DIV and REM.
  function automatic logic md_b_signed(input logic [2:0] op);
    return op[2] ? !op[0] : !op[1];
  endfunction

endpackage

// File: rtl/execute_stage_p_muldiv.sv
// Iterative RV32M/RV64M unit. Works on operand magnitudes: shift-add multiply
// into a 2*XLEN product, restoring divide into quotient/remainder, one step per
// cycle for XLEN cycles, then a sign fix on the combinational result path.
// acc holds the product high half / remainder, lo the product low half /
// dividend-then-quotient.
module muldiv_iter
  import execute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic            neg_p_q, neg_p_d;   // product / quotient needs negating
  logic            neg_a_q, neg_a_d;   // remainder takes the dividend's sign
  logic            div0_q, div0_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  assign a_neg = md_a_signed(op_i) & a_i[XLEN-1];
  assign b_neg = md_b_signed(op_i) & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // One multiply step adds the multiplicand when the current multiplier bit is set.
  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  // One restoring-divide step: shift in the next dividend bit, trial-subtract.
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};

  // Next-state: flush kills the op, start loads magnitudes, otherwise iterate.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    count_d = count_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_p_d = neg_p_q;
    neg_a_d = neg_a_q;
    div0_d  = div0_q;
    if (flush_i) begin
      count_d = '0;
    end else if (start_i) begin
      count_d = CW'(XLEN);
      op_d    = op_i;
      acc_d   = '0;
      neg_a_d = a_neg;
      div0_d  = (b_i == '0);
      if (op_i[2]) begin
        lo_d    = a_mag;
        mcand_d = b_mag;
        // Division by zero returns an all-ones quotient, never its negation.
        neg_p_d = (a_neg ^ b_neg) & (b_i != '0);
      end else begin
        lo_d    = b_mag;
        mcand_d = a_mag;
        neg_p_d = a_neg ^ b_neg;
      end
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          acc_d = div_diff[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = div_shift[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_p_q <= 1'b0;
      neg_a_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      count_q <= count_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_p_q <= neg_p_d;
      neg_a_q <= neg_a_d;
      div0_q  <= div0_d;
    end
  end

  assign done_o = (count_q == '0);

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem;

  assign prod     = {acc_q, lo_q};
  assign prod_fix = neg_p_q ? -prod : prod;
  // MIN / -1 falls out naturally: |MIN|/1 = MIN with both signs cancelling.
  assign quo      = div0_q ? '1 : (neg_p_q ? -lo_q : lo_q);
  assign rem      = neg_a_q ? -acc_q : acc_q;

  // Select the requested half / quotient / remainder.
  always_comb begin
    result_o = '0;
    case (op_q)
      MD_MUL:                       result_o = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_o = quo;
      default:                      result_o = rem;
    endcase
  end

endmodule

// File: rtl/execute_stage_p.sv
// Execute stage between decode/register-read and memory: single-cycle ALU,
// branch/jump resolution, optional iterative multiply/divide, and a registered
// EX/MEM output with valid/ready handshakes and a flush for branch redirect.
module execute_stage_p
  import execute_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter int              MD_EN  = 1,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rd,
  input  logic [2:0]      i_alu_op,
  input  logic            i_sub,
  input  logic            i_arith,
  input  logic            i_src_imm,
  input  logic            i_src_pc,
  input  logic            i_lui,
  input  logic            i_branch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_md,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_br_taken,
  output logic [XLEN-1:0] o_br_target
);

  localparam int   SHW   = $clog2(XLEN);
  localparam logic MD_ON = (MD_EN != 0);

  // ---------------- combinational execute ----------------
  logic [XLEN-1:0] op1, op2, alu_res, link, jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            br_cond;
  logic [XLEN-1:0] ex_result, ex_target;
  logic            ex_taken;

  assign op1      = i_src_pc ? i_pc : (i_lui ? '0 : i_rs1);
  assign op2      = i_src_imm ? i_imm : i_rs2;
  assign shamt    = op2[SHW-1:0];
  assign link     = i_pc + XLEN'(4);
  assign jalr_sum = i_rs1 + i_imm;

  // ALU function select.
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      ALU_ADD:  alu_res = i_sub ? (op1 - op2) : (op1 + op2);
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SR: begin
        // Kept as separate branches: inside one ?: the unsigned arm would turn
        // the arithmetic shift into a logical one.
        if (i_arith) alu_res = $signed(op1) >>> shamt;
        else         alu_res = op1 >> shamt;
      end
      ALU_OR:   alu_res = op1 | op2;
      default:  alu_res = op1 & op2;
    endcase
  end

  // Conditional branch compare on rs1 vs rs2.
  always_comb begin
    br_cond = 1'b0;
    case (i_alu_op)
      BR_EQ:   br_cond = (i_rs1 == i_rs2);
      BR_NE:   br_cond = (i_rs1 != i_rs2);
      BR_LT:   br_cond = ($signed(i_rs1) < $signed(i_rs2));
      BR_GE:   br_cond = ($signed(i_rs1) >= $signed(i_rs2));
      BR_LTU:  br_cond = (i_rs1 < i_rs2);
      BR_GEU:  br_cond = (i_rs1 >= i_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  // Single-cycle result, redirect flag and target for the current op.
  always_comb begin
    ex_result = alu_res;
    ex_taken  = 1'b0;
    ex_target = i_pc + i_imm;
    if (i_md) begin
      // Only reached when the md unit is absent: the op retires as a no-op.
      ex_result = '0;
    end else if (i_jal || i_jalr) begin
      ex_result = link;
      ex_taken  = 1'b1;
      if (i_jalr) ex_target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
    end else if (i_branch) begin
      ex_taken = br_cond;
    end
  end

  // ---------------- md unit ----------------
  logic            md_start, md_done, md_load;
  logic [XLEN-1:0] md_result;

  generate
    if (MD_EN != 0) begin : gen_md
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush_i  (i_flush),
        .start_i  (md_start),
        .op_i     (i_alu_op),
        .a_i      (i_rs1),
        .b_i      (i_rs2),
        .done_o   (md_done),
        .result_o (md_result)
      );
    end else begin : gen_no_md
      assign md_done   = 1'b1;
      assign md_result = '0;
    end
  endgenerate

  // ---------------- FSM ----------------
  state_t state_q, state_d;
  logic   valid_q, out_free, accept;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: md ops occupy the unit until the result reaches the output.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (md_start) state_d = BUSY;
        BUSY:    if (md_done) state_d = out_free ? IDLE : WAIT;
        WAIT:    if (out_free) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake and md start/retire strobes.
  always_comb begin
    out_free = !valid_q || i_ready;
    o_ready  = (state_q == IDLE) && out_free && !i_flush;
    accept   = i_valid && o_ready;
    md_start = accept && i_md && MD_ON;
    md_load  = !i_flush && out_free &&
               (((state_q == BUSY) && md_done) || (state_q == WAIT));
  end

  // ---------------- EX/MEM output register ----------------
  logic            valid_d;
  logic [XLEN-1:0] result_q, result_d, target_q, target_d;
  logic [4:0]      rd_q, rd_d, md_rd_q, md_rd_d;
  logic            taken_q, taken_d;

  // Output register load/hold/clear; flush beats everything.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    taken_d  = taken_q;
    target_d = target_q;
    md_rd_d  = md_rd_q;
    if (md_start) md_rd_d = i_rd;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept && !md_start) begin
      valid_d  = 1'b1;
      result_d = ex_result;
      rd_d     = i_rd;
      taken_d  = ex_taken;
      target_d = ex_target;
    end else if (md_load) begin
      valid_d  = 1'b1;
      result_d = md_result;
      rd_d     = md_rd_q;
      taken_d  = 1'b0;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output and md destination-tag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= RST_PC;
      md_rd_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      md_rd_q  <= md_rd_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_rd        = rd_q;
  assign o_br_taken  = taken_q;
  assign o_br_target = target_q;

endmodule

// File: tb/tb_execute_stage_p.sv
// Directed bench for execute_stage_p (XLEN=32, MD_EN=1, RST_PC=0): a table of
// single-cycle ops plus hand-written md, handshake, flush and reset sequences.
module tb_execute_stage_p;

  logic        clk, rst_n, i_flush, i_valid, o_ready;
  logic [31:0] i_pc, i_rs1, i_rs2, i_imm;
  logic [4:0]  i_rd;
  logic [2:0]  i_alu_op;
  logic        i_sub, i_arith, i_src_imm, i_src_pc, i_lui;
  logic        i_branch, i_jal, i_jalr, i_md;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_br_taken;
  logic [31:0] o_br_target;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage_p #(.XLEN(32), .MD_EN(1), .RST_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_imm(i_imm), .i_rd(i_rd), .i_alu_op(i_alu_op), .i_sub(i_sub),
    .i_arith(i_arith), .i_src_imm(i_src_imm), .i_src_pc(i_src_pc),
    .i_lui(i_lui), .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
    .i_md(i_md), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_rd(o_rd), .o_br_taken(o_br_taken), .o_br_target(o_br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        sub, arith, src_imm, src_pc, lui, branch, jal, jalr;
    logic [31:0] pc, rs1, rs2, imm;
    logic [31:0] exp_res;
    logic        chk_res;
    logic        exp_taken;
    logic [31:0] exp_tgt;
    logic        chk_tgt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    i_valid = 0; i_pc = 0; i_rs1 = 0; i_rs2 = 0; i_imm = 0; i_rd = 0;
    i_alu_op = 0; i_sub = 0; i_arith = 0; i_src_imm = 0; i_src_pc = 0;
    i_lui = 0; i_branch = 0; i_jal = 0; i_jalr = 0; i_md = 0;
  endtask

  // Issue an md op, measure cycles to o_valid and cycles with o_ready low.
  task automatic run_md(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    int lows;
    clr_inputs();
    i_md = 1; i_alu_op = op; i_rs1 = a; i_rs2 = b; i_rd = 5'd17; i_valid = 1;
    check({name, "_ready_in"}, 32'(o_ready), 32'd1);
    step();
    clr_inputs();
    n = 0;
    lows = 0;
    while (!o_valid && n < 100) begin
      if (!o_ready) lows++;
      step();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd33);
    check({name, "_ready_low"}, 32'(lows), 32'd33);
    check({name, "_result"}, o_result, exp);
    check({name, "_rd"}, 32'(o_rd), 32'd17);
    check({name, "_taken"}, 32'(o_br_taken), 32'd0);
    step();
    check({name, "_clear"}, 32'(o_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    // name, op, sub, arith, src_imm, src_pc, lui, branch, jal, jalr, pc, rs1, rs2, imm, exp_res, chk_res, exp_taken, exp_tgt, chk_tgt
    vecs.push_back('{"addi",  3'd0, 0,0,1,0,0,0,0,0, 32'h0,    32'd5,        32'd0,        32'hFFFFFFF9, 32'hFFFFFFFE, 1, 0, 32'h0,    0});
    vecs.push_back('{"sub",   3'd0, 1,0,0,0,0,0,0,0, 32'h0,    32'd10,       32'd3,        32'h0,        32'd7,        1, 0, 32'h0,    0});
    vecs.push_back('{"sll",   3'd1, 0,0,0,0,0,0,0,0, 32'h0,    32'd1,        32'h25,       32'h0,        32'h20,       1, 0, 32'h0,    0});
    vecs.push_back('{"slt",   3'd2, 0,0,0,0,0,0,0,0, 32'h0,    32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        1, 0, 32'h0,    0});
    vecs.push_back('{"sltu",  3'd3, 0,0,0,0,0,0,0,0, 32'h0,    32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        1, 0, 32'h0,    0});
    vecs.push_back('{"xor",   3'd4, 0,0,0,0,0,0,0,0, 32'h0,    32'hF0F0,     32'h0FF0,     32'h0,        32'hFF00,     1, 0, 32'h0,    0});
    vecs.push_back('{"srl",   3'd5, 0,0,0,0,0,0,0,0, 32'h0,    32'h80000000, 32'd4,        32'h0,        32'h08000000, 1, 0, 32'h0,    0});
    vecs.push_back('{"sra",   3'd5, 0,1,0,0,0,0,0,0, 32'h0,    32'h80000000, 32'd4,        32'h0,        32'hF8000000, 1, 0, 32'h0,    0});
    vecs.push_back('{"or",    3'd6, 0,0,0,0,0,0,0,0, 32'h0,    32'hF0,       32'h0F,       32'h0,        32'hFF,       1, 0, 32'h0,    0});
    vecs.push_back('{"and",   3'd7, 0,0,0,0,0,0,0,0, 32'h0,    32'hF0,       32'h3C,       32'h0,        32'h30,       1, 0, 32'h0,    0});
    vecs.push_back('{"lui",   3'd0, 0,0,1,0,1,0,0,0, 32'h0,    32'hDEAD,     32'h0,        32'h12345000, 32'h12345000, 1, 0, 32'h0,    0});
    vecs.push_back('{"auipc", 3'd0, 0,0,1,1,0,0,0,0, 32'h1000, 32'hDEAD,     32'h0,        32'h2000,     32'h3000,     1, 0, 32'h0,    0});
    vecs.push_back('{"blt",   3'd4, 0,0,0,0,0,1,0,0, 32'h100,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        0, 1, 32'h120,  1});
    vecs.push_back('{"bltu",  3'd6, 0,0,0,0,0,1,0,0, 32'h100,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        0, 0, 32'h0,    0});
    vecs.push_back('{"beq",   3'd0, 0,0,0,0,0,1,0,0, 32'h200,  32'd5,        32'd5,        32'hFFFFFFF0, 32'h0,        0, 1, 32'h1F0,  1});
    vecs.push_back('{"bne",   3'd1, 0,0,0,0,0,1,0,0, 32'h200,  32'd5,        32'd5,        32'h10,       32'h0,        0, 0, 32'h0,    0});
    vecs.push_back('{"bge",   3'd5, 0,0,0,0,0,1,0,0, 32'h300,  32'd1,        32'hFFFFFFFF, 32'h8,        32'h0,        0, 1, 32'h308,  1});
    vecs.push_back('{"bgeu",  3'd7, 0,0,0,0,0,1,0,0, 32'h300,  32'd1,        32'hFFFFFFFF, 32'h8,        32'h0,        0, 0, 32'h0,    0});
    vecs.push_back('{"br010", 3'd2, 0,0,0,0,0,1,0,0, 32'h300,  32'd7,        32'd7,        32'h8,        32'h0,        0, 0, 32'h0,    0});
    vecs.push_back('{"jal",   3'd0, 0,0,1,0,0,0,1,0, 32'h200,  32'h0,        32'h0,        32'h10,       32'h204,      1, 1, 32'h210,  1});
    vecs.push_back('{"jalr",  3'd0, 0,0,1,0,0,0,0,1, 32'h40,   32'h1003,     32'h0,        32'h4,        32'h44,       1, 1, 32'h1006, 1});

    clr_inputs();
    i_flush = 0;
    i_ready = 1;
    rst_n   = 0;
    #12;
    check("rst_valid",  32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'h0);
    check("rst_rd",     32'(o_rd), 32'd0);
    check("rst_taken",  32'(o_br_taken), 32'd0);
    check("rst_target", o_br_target, 32'h0);
    check("rst_ready",  32'(o_ready), 32'd1);
    rst_n = 1;
    step();

    // Single-cycle table, issued back to back
    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      i_alu_op = t.op; i_sub = t.sub; i_arith = t.arith; i_src_imm = t.src_imm;
      i_src_pc = t.src_pc; i_lui = t.lui; i_branch = t.branch; i_jal = t.jal;
      i_jalr = t.jalr; i_pc = t.pc; i_rs1 = t.rs1; i_rs2 = t.rs2; i_imm = t.imm;
      i_rd = 5'(i + 1); i_md = 0; i_valid = 1;
      check({t.name, "_ready"}, 32'(o_ready), 32'd1);
      step();
      i_valid = 0;
      check({t.name, "_valid"}, 32'(o_valid), 32'd1);
      check({t.name, "_rd"}, 32'(o_rd), 32'(i + 1));
      check({t.name, "_taken"}, 32'(o_br_taken), 32'(t.exp_taken));
      if (t.chk_res) check({t.name, "_result"}, o_result, t.exp_res);
      if (t.chk_tgt) check({t.name, "_target"}, o_br_target, t.exp_tgt);
    end
    step();
    check("table_clear", 32'(o_valid), 32'd0);

    // Multiply / divide
    run_md("mul",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_md("mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md("mulh",       3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF);
    run_md("mulhsu",     3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    run_md("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_md("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_md("rem_div0",   3'd6, 32'd13,       32'd0,        32'd13);
    run_md("divu_div0",  3'd5, 32'd13,       32'd0,        32'hFFFFFFFF);
    run_md("div_negdiv0",3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    run_md("div_neg",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_md("rem_neg",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_md("divu",       3'd5, 32'd100,      32'd7,        32'd14);

    // Output hold under downstream stall; a waiting op must not be taken
    clr_inputs();
    i_ready = 0;
    i_alu_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4; i_rd = 5'd9; i_valid = 1;
    step();
    i_rs1 = 32'd100; i_rd = 5'd10;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid",  32'(o_valid), 32'd1);
      check("hold_result", o_result, 32'd7);
      check("hold_rd",     32'(o_rd), 32'd9);
      check("hold_ready",  32'(o_ready), 32'd0);
      step();
    end
    check("hold_result_end", o_result, 32'd7);
    i_ready = 1;
    #1;
    check("hold_release_ready", 32'(o_ready), 32'd1);
    step();
    i_valid = 0;
    check("hold_next_result", o_result, 32'd104);
    check("hold_next_rd",     32'(o_rd), 32'd10);
    step();
    check("hold_clear", 32'(o_valid), 32'd0);

    // Flush kills a stalled output; the op presented alongside is not accepted
    i_ready = 0;
    i_alu_op = 3'd0; i_rs1 = 32'd1; i_rs2 = 32'd1; i_rd = 5'd3; i_valid = 1;
    step();
    check("fl_out_valid", 32'(o_valid), 32'd1);
    i_ready = 1;
    i_flush = 1;
    #1;
    check("fl_out_ready", 32'(o_ready), 32'd0);
    step();
    i_flush = 0;
    i_valid = 0;
    check("fl_out_cleared", 32'(o_valid), 32'd0);

    // Flush at BUSY cycle 10 discards the md op
    begin
      int seen;
      clr_inputs();
      i_md = 1; i_alu_op = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_rd = 5'd4; i_valid = 1;
      step();
      clr_inputs();
      for (int k = 0; k < 10; k++) step();
      check("fl_md_busy", 32'(o_ready), 32'd0);
      i_flush = 1;
      #1;
      check("fl_md_ready_in_flush", 32'(o_ready), 32'd0);
      step();
      i_flush = 0;
      #1;
      check("fl_md_ready", 32'(o_ready), 32'd1);
      check("fl_md_valid", 32'(o_valid), 32'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (o_valid) seen++;
        step();
      end
      check("fl_md_discarded", 32'(seen), 32'd0);
    end
    run_md("remu_after_flush", 3'd7, 32'd100, 32'd7, 32'd2);

    // Asynchronous reset in the middle of a multiply
    clr_inputs();
    i_md = 1; i_alu_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_rd = 5'd8; i_valid = 1;
    step();
    clr_inputs();
    for (int k = 0; k < 5; k++) step();
    #2;
    rst_n = 0;
    #1;
    check("ar_valid",  32'(o_valid), 32'd0);
    check("ar_result", o_result, 32'h0);
    check("ar_rd",     32'(o_rd), 32'd0);
    check("ar_taken",  32'(o_br_taken), 32'd0);
    check("ar_target", o_br_target, 32'h0);
    check("ar_ready",  32'(o_ready), 32'd1);
    #1;
    rst_n = 1;
    step();
    run_md("mul_after_reset", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
